// File: rtl/control_cmd_writeregion.sv
// Region-write command consumer: header (x0,y0,w-1,h-1) then clipped payload to FB RAM.
// Optional CMD_REGION_WRAP_EN: wrap coordinates instead of clipping.
module control_cmd_writeregion #(
  parameter int PIXEL_WIDTH     = 64,
  parameter int PIXEL_HEIGHT    = 32,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int COORD_BITS      = 8,
  localparam int CB = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1,
  localparam int RB = (PIXEL_HEIGHT > 1) ? $clog2(PIXEL_HEIGHT) : 1,
  localparam int PB = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1,
  localparam int AW = RB + CB + PB
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [7:0]    data_in,
  output logic [AW-1:0] addr,
  output logic [7:0]    data_out,
  output logic          ram_write_enable,
  output logic          ram_access_start,
  output logic          busy,
  output logic          done
);

  localparam int XW = COORD_BITS + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDRY = 3'd1;
  localparam logic [2:0] S_HDRW = 3'd2;
  localparam logic [2:0] S_HDRH = 3'd3;
  localparam logic [2:0] S_PAY  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [PB-1:0] PIX_TOP = PB'(BYTES_PER_PIXEL - 1);

  logic [2:0]            state_q, state_d;
  logic [COORD_BITS-1:0] x0_q, x0_d;
  logic [COORD_BITS-1:0] y0_q, y0_d;
  logic [COORD_BITS-1:0] wm1_q, wm1_d;
  logic [COORD_BITS-1:0] hm1_q, hm1_d;
  logic [COORD_BITS-1:0] col_q, col_d;
  logic [COORD_BITS-1:0] row_q, row_d;
  logic [PB-1:0]         pix_q, pix_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [7:0]            data_q, data_d;
  logic                  we_q, we_d;
  logic                  tog_q, tog_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [XW-1:0] x_sum, y_sum;
  logic [CB-1:0] x_pos;
  logic [RB-1:0] y_pos;
  logic          hit;
  logic          last;

  assign x_sum = XW'(x0_q) + XW'(col_q);
  assign y_sum = XW'(y0_q) + XW'(row_q);

`ifdef CMD_REGION_WRAP_EN
  // Wrap is gated only by the latched origin, not by the running position.
  assign x_pos = CB'(x_sum % XW'(PIXEL_WIDTH));
  assign y_pos = RB'(y_sum % XW'(PIXEL_HEIGHT));
  assign hit   = (XW'(x0_q) < XW'(PIXEL_WIDTH)) &&
                 (XW'(y0_q) < XW'(PIXEL_HEIGHT));
`else
  assign x_pos = CB'(x_sum);
  assign y_pos = RB'(y_sum);
  assign hit   = (x_sum < XW'(PIXEL_WIDTH)) &&
                 (y_sum < XW'(PIXEL_HEIGHT));
`endif

  assign last = (row_q == hm1_q) && (col_q == wm1_q) &&
                (pix_q == '0);

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    wm1_d   = wm1_q;
    hm1_d   = hm1_q;
    col_d   = col_q;
    row_d   = row_q;
    pix_d   = pix_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    tog_d   = tog_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (enable) begin
          x0_d    = COORD_BITS'(data_in);
          busy_d  = 1'b1;
          state_d = S_HDRY;
        end
      end
      (state_q == S_HDRY): begin
        if (enable) begin
          y0_d    = COORD_BITS'(data_in);
          state_d = S_HDRW;
        end
      end
      (state_q == S_HDRW): begin
        if (enable) begin
          wm1_d   = COORD_BITS'(data_in);
          state_d = S_HDRH;
        end
      end
      (state_q == S_HDRH): begin
        if (enable) begin
          hm1_d   = COORD_BITS'(data_in);
          col_d   = '0;
          row_d   = '0;
          pix_d   = PIX_TOP;
          state_d = S_PAY;
        end
      end
      (state_q == S_PAY): begin
        if (enable) begin
          data_d = data_in;
          we_d   = 1'b1;
          if (hit) begin
            addr_d = {y_pos, x_pos, pix_q};
            tog_d  = ~tog_q;
          end
          if (pix_q == '0) begin
            pix_d = PIX_TOP;
            if (col_q == wm1_q) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            pix_d = pix_q - 1'b1;
          end
          if (last) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      (state_q == S_DONE): begin
        busy_d  = 1'b0;
        we_d    = 1'b0;
        data_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      wm1_q   <= '0;
      hm1_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      pix_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      tog_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      wm1_q   <= wm1_d;
      hm1_q   <= hm1_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pix_q   <= pix_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      tog_q   <= tog_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign addr             = addr_q;
  assign data_out         = data_q;
  assign ram_write_enable = we_q;
  assign ram_access_start = tog_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule
